// File: rtl/demux_lane_scheduler.sv
// Round-robin demultiplexer: distributes an input stream across four
// single-entry lane buffers, skipping disabled lanes and honouring per-lane backpressure.
module demux_lane_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [3:0]       lane_en,
  input  logic             flush,
  output logic [WIDTH-1:0] dout_0,
  output logic [WIDTH-1:0] dout_1,
  output logic [WIDTH-1:0] dout_2,
  output logic [WIDTH-1:0] dout_3,
  output logic             dout_valid_0,
  output logic             dout_valid_1,
  output logic             dout_valid_2,
  output logic             dout_valid_3,
  input  logic             dout_ready_0,
  input  logic             dout_ready_1,
  input  logic             dout_ready_2,
  input  logic             dout_ready_3,
  output logic             sel_0,
  output logic             sel_1
);

  logic [1:0]       ptr;
  logic [1:0]       ptr_next;
  logic [3:0]       vld;
  logic [WIDTH-1:0] dat [4];
  logic [3:0]       rdy;
  logic             xfer;

  // First enabled lane in the order cur+1, cur+2, cur+3, cur; cur if none is enabled.
  function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] result;
    logic [1:0] cand;
    result = cur;
    for (int i = 3; i >= 1; i--) begin
      cand = cur + 2'(i);
      if (en[cand]) result = cand;
    end
    return result;
  endfunction

  assign rdy = {dout_ready_3, dout_ready_2, dout_ready_1, dout_ready_0};

  // The slot at ptr can take a word if it is empty or is being drained this cycle.
  assign din_ready = ~reset & lane_en[ptr] & ~flush & (~vld[ptr] | rdy[ptr]);
  assign xfer      = din_valid & din_ready;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ptr_next = ptr;
    if (flush) begin
      ptr_next = 2'd0;
    end else if (lane_en != 4'b0000 && (xfer || !lane_en[ptr])) begin
      ptr_next = next_enabled(ptr, lane_en);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 2'd0;
      vld <= 4'b0000;
    end else begin
      ptr <= ptr_next;
      for (int k = 0; k < 4; k++) begin
        if (flush) begin
          vld[k] <= 1'b0;
        end else if (xfer && ptr == 2'(k)) begin
          vld[k] <= 1'b1;
        end else if (rdy[k]) begin
          vld[k] <= 1'b0;
        end
      end
    end
  end

  // NOTE: lane data is reset because the outputs must read zero while reset is held;
  // flush deliberately leaves it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) dat[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (xfer && ptr == 2'(k)) dat[k] <= din;
      end
    end
  end

  assign dout_0       = dat[0];
  assign dout_1       = dat[1];
  assign dout_2       = dat[2];
  assign dout_3       = dat[3];
  assign dout_valid_0 = vld[0];
  assign dout_valid_1 = vld[1];
  assign dout_valid_2 = vld[2];
  assign dout_valid_3 = vld[3];
  assign sel_0        = ptr[1];
  assign sel_1        = ptr[0];

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Self-checking bench for demux_lane_scheduler: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a lane/pointer model.
module tb_demux_lane_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] lane_en;
  logic       flush;
  logic [3:0] rdy;
  logic [7:0] dout_0, dout_1, dout_2, dout_3;
  logic       dout_valid_0, dout_valid_1, dout_valid_2, dout_valid_3;
  logic       sel_0, sel_1;

  logic [7:0] dout_a [4];
  logic [3:0] vld_a;

  int total = 0;
  int bad   = 0;

  // Reference state: which lanes hold a word, what they hold, where the pointer is.
  int         m_ptr;
  bit         m_vld [4];
  logic [7:0] m_dat [4];
  bit         m_ready;
  bit         m_xfer;

  demux_lane_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .lane_en(lane_en), .flush(flush),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2), .dout_3(dout_3),
    .dout_valid_0(dout_valid_0), .dout_valid_1(dout_valid_1),
    .dout_valid_2(dout_valid_2), .dout_valid_3(dout_valid_3),
    .dout_ready_0(rdy[0]), .dout_ready_1(rdy[1]), .dout_ready_2(rdy[2]), .dout_ready_3(rdy[3]),
    .sel_0(sel_0), .sel_1(sel_1)
  );

  assign dout_a[0] = dout_0;
  assign dout_a[1] = dout_1;
  assign dout_a[2] = dout_2;
  assign dout_a[3] = dout_3;
  assign vld_a     = {dout_valid_3, dout_valid_2, dout_valid_1, dout_valid_0};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: check the DUT against the model, then advance the model by one edge.
  always @(negedge clk) begin
    if (reset) begin
      m_ptr = 0;
      for (int k = 0; k < 4; k++) begin
        m_vld[k] = 1'b0;
        m_dat[k] = 8'h00;
      end
    end
    m_ready = !reset && lane_en[m_ptr] && !flush && (!m_vld[m_ptr] || rdy[m_ptr]);
    check("din_ready", din_ready, m_ready);
    check("sel", {sel_0, sel_1}, m_ptr[1:0]);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("dout_valid_%0d", k), vld_a[k], m_vld[k]);
      check($sformatf("dout_%0d", k), dout_a[k], m_dat[k]);
    end
    if (!reset) begin
      if (flush) begin
        for (int k = 0; k < 4; k++) m_vld[k] = 1'b0;
        m_ptr = 0;
      end else begin
        m_xfer = din_valid && m_ready;
        for (int k = 0; k < 4; k++) begin
          if (m_xfer && k == m_ptr) begin
            m_vld[k] = 1'b1;
            m_dat[k] = din;
          end else if (m_vld[k] && rdy[k]) begin
            m_vld[k] = 1'b0;
          end
        end
        if (lane_en != 4'b0000 && (m_xfer || !lane_en[m_ptr])) begin
          for (int i = 1; i <= 4; i++) begin
            if (lane_en[(m_ptr + i) % 4]) begin
              m_ptr = (m_ptr + i) % 4;
              break;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] rr_vals [5];
    logic [7:0] bp_vals [7];
    rr_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bp_vals = '{8'h70, 8'h71, 8'h72, 8'hAB, 8'h73, 8'h74, 8'h75};

    reset = 1'b1; din = 8'h00; din_valid = 1'b0; lane_en = 4'h0; flush = 1'b0; rdy = 4'h0;
    #3;
    check("rst_din_ready", din_ready, 1'b0);
    check("rst_sel", {sel_0, sel_1}, 2'b00);
    check("rst_valid", vld_a, 4'h0);
    check("rst_dout0", dout_0, 8'h00);
    step();
    step();
    reset = 1'b0;

    // Round robin over all four lanes.
    lane_en = 4'hF; rdy = 4'hF; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = rr_vals[i];
      #1;
      check("rr_ready", din_ready, 1'b1);
      step();
      check("rr_dout", dout_a[i % 4], rr_vals[i]);
      check("rr_valid", vld_a[i % 4], 1'b1);
    end
    din_valid = 1'b0;
    repeat (2) step();

    // Skip: pointer at 1, only lanes 0 and 2 enabled.
    lane_en = 4'b0101; din_valid = 1'b1; din = 8'h60;
    step();
    check("skip_idle_sel", {sel_0, sel_1}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      din = 8'h61 + 8'(i);
      step();
      check("skip_dout", dout_a[(i % 2 == 0) ? 2 : 0], 8'h61 + 8'(i));
      check("skip_sel", {sel_0, sel_1}, (i % 2 == 0) ? 2'b00 : 2'b10);
    end
    din_valid = 1'b0;

    // Backpressure on lane 1.
    lane_en = 4'hF; rdy = 4'b1101; din_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = bp_vals[i];
      step();
    end
    check("bp_ready", din_ready, 1'b0);
    check("bp_sel", {sel_0, sel_1}, 2'b01);
    check("bp_hold", dout_1, 8'hAB);
    step();
    check("bp_hold2", dout_1, 8'hAB);
    check("bp_valid2", dout_valid_1, 1'b1);
    rdy[1] = 1'b1; din = 8'hCD;
    #1;
    check("bp_release_ready", din_ready, 1'b1);
    step();
    check("bp_pass", dout_1, 8'hCD);
    check("bp_pass_valid", dout_valid_1, 1'b1);

    // Flush with lanes 0 and 3 valid and pointer at 2.
    din_valid = 1'b0; rdy = 4'hF;
    repeat (2) step();
    rdy = 4'h0; lane_en = 4'b1001; din_valid = 1'b1; din = 8'h5A;
    repeat (3) step();
    lane_en = 4'b0100;
    step();
    check("fl_sel_pre", {sel_0, sel_1}, 2'b10);
    check("fl_valid_pre", vld_a, 4'b1001);
    flush = 1'b1;
    #1;
    check("fl_ready", din_ready, 1'b0);
    step();
    check("fl_valid", vld_a, 4'h0);
    check("fl_sel", {sel_0, sel_1}, 2'b00);
    check("fl_dout0_kept", dout_0, 8'h5A);
    flush = 1'b0;

    // Mask edge cases.
    lane_en = 4'h0; din_valid = 1'b1; din = 8'h8F;
    #1;
    check("m0_ready", din_ready, 1'b0);
    repeat (2) step();
    check("m0_sel", {sel_0, sel_1}, 2'b00);
    lane_en = 4'b1000;
    #1;
    check("m8_idle_ready", din_ready, 1'b0);
    step();
    check("m8_sel", {sel_0, sel_1}, 2'b11);
    rdy = 4'hF;
    for (int i = 0; i < 3; i++) begin
      din = 8'h90 + 8'(i);
      #1;
      check("m8_ready", din_ready, 1'b1);
      step();
      check("m8_dout3", dout_3, 8'h90 + 8'(i));
      check("m8_sel_hold", {sel_0, sel_1}, 2'b11);
    end

    // Asynchronous reset between edges while lane 3 holds a word.
    lane_en = 4'hF; rdy = 4'h0; din_valid = 1'b1; din = 8'hEE;
    step();
    check("ar_pre_valid", dout_valid_3, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", vld_a, 4'h0);
    check("ar_dout3", dout_3, 8'h00);
    check("ar_sel", {sel_0, sel_1}, 2'b00);
    step();
    reset = 1'b0; din_valid = 1'b0;
    step();
    check("ar_after_valid", vld_a, 4'h0);

    // Randomized traffic, checked by the compare process.
    repeat (3000) begin
      din       = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      lane_en   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : (4'($urandom) | 4'b0001);
      rdy       = 4'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; din_valid = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
